// File: rtl/pla_map_pkg.sv
// ============================================================================
// pla_map_pkg
// Shared types and attribute bit offsets for the programmable PLA decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pla_map_pkg;

    // Table fields are stored at this width; ADDR_W must not exceed it.
    localparam int MAX_ADDR_W = 32;

    // Attribute flag positions, relative to SEL_W (the select-code width).
    localparam int ATTR_EN_OFS  = 0;
    localparam int ATTR_RO_OFS  = 1;
    localparam int ATTR_VIC_OFS = 2;

    typedef enum logic [1:0] {
        FIELD_BASE = 2'd0,
        FIELD_MASK = 2'd1,
        FIELD_ATTR = 2'd2
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] base;
        logic [MAX_ADDR_W-1:0] mask;
        logic [MAX_ADDR_W-1:0] attr;
    } region_t;

endpackage

`default_nettype wire

// File: rtl/pla_map_match.sv
// ============================================================================
// pla_map_match
// Combinational match of one table region against the bus address.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pla_map_match
    import pla_map_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int N_SEL  = 16,
    parameter int SEL_W  = $clog2(N_SEL)
) (
    input  region_t           region,
    input  logic [ADDR_W-1:0] addr,
    input  logic              aec,
    output logic              hit,
    output logic              ro,
    output logic [SEL_W-1:0]  code
);

    logic [MAX_ADDR_W-1:0] addr_ext;
    logic                  addr_eq;
    logic                  enabled;
    logic                  vic_ok;

    assign addr_ext = MAX_ADDR_W'(addr);
    assign addr_eq  = ((addr_ext ^ region.base) & region.mask) == '0;
    assign enabled  = region.attr[SEL_W + ATTR_EN_OFS];
    // In the VIC phase only regions flagged VIC-visible take part.
    assign vic_ok   = aec | region.attr[SEL_W + ATTR_VIC_OFS];

    assign hit  = enabled & addr_eq & vic_ok;
    assign ro   = region.attr[SEL_W + ATTR_RO_OFS];
    assign code = region.attr[SEL_W-1:0];

endmodule

`default_nettype wire

// File: rtl/pla_map.sv
// ============================================================================
// pla_map
// Programmable, double-buffered address decoder driving one-hot chip selects
// plus dwe/casenb. Optional staged-table readback: PLA_MAP_READBACK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pla_map
    import pla_map_pkg::*;
#(
    parameter  int ADDR_W    = 16,
    parameter  int N_REGIONS = 8,
    parameter  int N_SEL     = 16,
    localparam int IDX_W     = $clog2(N_REGIONS),
    localparam int SEL_W     = $clog2(N_SEL)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aec,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [1:0]        cfg_field,
    input  logic [ADDR_W-1:0] cfg_wdata,
    input  logic              cfg_commit,
    output logic              cfg_busy,
    output logic [ADDR_W-1:0] cfg_rdata,
    output logic [N_SEL-1:0]  sel,
    output logic              ramsel,
    output logic              dwe,
    output logic              casenb,
    output logic              wprot
);

    region_t    staged [N_REGIONS];
    region_t    live   [N_REGIONS];
    state_e     state;

    logic              hit_v  [N_REGIONS];
    logic              ro_v   [N_REGIONS];
    logic [SEL_W-1:0]  code_v [N_REGIONS];

    logic              any_hit;
    logic              win_ro;
    logic [SEL_W-1:0]  win_code;

    generate
        for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
            pla_map_match #(
                .ADDR_W (ADDR_W),
                .N_SEL  (N_SEL)
            ) u_match (
                .region (live[g]),
                .addr   (addr),
                .aec    (aec),
                .hit    (hit_v[g]),
                .ro     (ro_v[g]),
                .code   (code_v[g])
            );
        end
    endgenerate

    // Scan high to low so the lowest matching index is the last to assign.
    always_comb begin
        any_hit  = 1'b0;
        win_ro   = 1'b0;
        win_code = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (hit_v[i]) begin
                any_hit  = 1'b1;
                win_ro   = ro_v[i];
                win_code = code_v[i];
            end
        end
    end

    assign cfg_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            for (int i = 0; i < N_REGIONS; i++) begin
                staged[i] <= '0;
                live[i]   <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        case (field_e'(cfg_field))
                            FIELD_BASE: staged[cfg_idx].base <= MAX_ADDR_W'(cfg_wdata);
                            FIELD_MASK: staged[cfg_idx].mask <= MAX_ADDR_W'(cfg_wdata);
                            FIELD_ATTR: staged[cfg_idx].attr <= MAX_ADDR_W'(cfg_wdata);
                            default: ;
                        endcase
                    end
                    if (cfg_commit) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!aec) state <= ST_APPLY;
                end
                ST_APPLY: begin
                    for (int i = 0; i < N_REGIONS; i++) live[i] <= staged[i];
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel    <= '0;
            ramsel <= 1'b0;
            dwe    <= 1'b0;
            casenb <= 1'b0;
            wprot  <= 1'b0;
        end else if (any_hit && win_ro && !rw) begin
            // ROM-style region: the write falls through to DRAM underneath.
            sel    <= '0;
            ramsel <= 1'b1;
            dwe    <= 1'b1;
            casenb <= 1'b0;
            wprot  <= 1'b1;
        end else if (any_hit) begin
            sel    <= N_SEL'(1) << win_code;
            ramsel <= 1'b0;
            dwe    <= 1'b0;
            casenb <= 1'b1;
            wprot  <= 1'b0;
        end else begin
            sel    <= '0;
            ramsel <= 1'b1;
            dwe    <= !rw && aec;
            casenb <= 1'b0;
            wprot  <= 1'b0;
        end
    end

`ifdef PLA_MAP_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_rdata <= '0;
        end else begin
            case (field_e'(cfg_field))
                FIELD_BASE: cfg_rdata <= staged[cfg_idx].base[ADDR_W-1:0];
                FIELD_MASK: cfg_rdata <= staged[cfg_idx].mask[ADDR_W-1:0];
                FIELD_ATTR: cfg_rdata <= staged[cfg_idx].attr[ADDR_W-1:0];
                default:    cfg_rdata <= '0;
            endcase
        end
    end
`else
    assign cfg_rdata = '0;
`endif

endmodule

`default_nettype wire
